// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared parameters, bus widths and FSM state type for the instruction cache
package icache_pkg;

    localparam int   ICACHE_INDEX_W = 8;
    localparam int   ICACHE_TAG_W   = 8;
    localparam int   INST_ADDR_W    = 32;
    localparam int   REG_W          = 32;
    localparam logic RST_ENABLE     = 1'b1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } icache_state_t;

    function automatic int icache_num(input int index_w);
        return 1 << index_w;
    endfunction

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped data/tag/valid storage, combinational read, synchronous write
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int TAG_W   = ICACHE_TAG_W
) (
    input  logic               clk_in,
    input  logic               clear_in,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [REG_W-1:0]   rd_data,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [REG_W-1:0]   wr_data
);

    localparam int LINES = icache_num(INDEX_W);

    logic [REG_W-1:0] data_mem [LINES];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid_q;

    // Only the valid bits are cleared; stale data/tag contents are harmless once invalid.
    always_ff @(posedge clk_in) begin
        if (clear_in) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            data_mem[wr_index] <= wr_data;
            tag_mem[wr_index]  <= wr_tag;
        end
    end

    assign rd_data  = data_mem[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with single-word miss fill and jump abort
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int TAG_W   = ICACHE_TAG_W
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   jump_or_not_in,
    input  logic                   if_enable_in,
    input  logic [INST_ADDR_W-1:0] if_address_in,
    output logic [REG_W-1:0]       if_inst_out,
    output logic                   if_valid_out,
    output logic                   mem_req_out,
    output logic [INST_ADDR_W-1:0] mem_address_out,
    input  logic [REG_W-1:0]       mem_data_in,
    input  logic                   mem_done_in,
    input  logic                   mem_busy_in
);

    localparam int IDX_LO = 2;
    localparam int IDX_HI = INDEX_W + 1;
    localparam int TAG_LO = INDEX_W + 2;
    localparam int TAG_HI = TAG_W + INDEX_W + 1;

    icache_state_t          state_q, state_d;
    logic [INST_ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic [INST_ADDR_W-1:0] mem_address_d;
    logic [REG_W-1:0]       if_inst_d;
    logic                   if_valid_d;
    logic                   mem_req_d;

    logic [REG_W-1:0]       rd_data;
    logic [TAG_W-1:0]       rd_tag;
    logic                   rd_valid;
    logic                   lookup_hit;
    logic                   wr_en;

    // Busy only stretches the miss; byte-offset and upper address bits carry no cache state.
    logic                   unused_inputs;
    assign unused_inputs = ^{mem_busy_in, if_address_in, miss_addr_q};

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk_in   (clk_in),
        .clear_in (rst_in == RST_ENABLE),
        .rd_index (if_address_in[IDX_HI:IDX_LO]),
        .rd_data  (rd_data),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_index (miss_addr_q[IDX_HI:IDX_LO]),
        .wr_tag   (miss_addr_q[TAG_HI:TAG_LO]),
        .wr_data  (mem_data_in)
    );

    assign lookup_hit = rd_valid && (rd_tag == if_address_in[TAG_HI:TAG_LO]);

    always_comb begin
        state_d       = state_q;
        miss_addr_d   = miss_addr_q;
        mem_req_d     = mem_req_out;
        mem_address_d = mem_address_out;
        if_inst_d     = if_inst_out;
        if_valid_d    = 1'b0;
        wr_en         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_enable_in && !jump_or_not_in) begin
                    if (lookup_hit) begin
                        if_inst_d  = rd_data;
                        if_valid_d = 1'b1;
                    end else begin
                        miss_addr_d   = if_address_in;
                        mem_address_d = if_address_in;
                        mem_req_d     = 1'b1;
                        state_d       = S_MISS;
                    end
                end
            end
            S_MISS: begin
                if (mem_done_in) begin
                    // The returned word belongs to miss_addr even when a jump arrives with it.
                    wr_en     = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                    if (!jump_or_not_in) begin
                        if_inst_d  = mem_data_in;
                        if_valid_d = 1'b1;
                    end
                end else if (jump_or_not_in) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in == RST_ENABLE) begin
            state_q         <= S_IDLE;
            miss_addr_q     <= '0;
            mem_req_out     <= 1'b0;
            mem_address_out <= '0;
            if_inst_out     <= '0;
            if_valid_out    <= 1'b0;
        end else begin
            state_q         <= state_d;
            miss_addr_q     <= miss_addr_d;
            mem_req_out     <= mem_req_d;
            mem_address_out <= mem_address_d;
            if_inst_out     <= if_inst_d;
            if_valid_out    <= if_valid_d;
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized scoreboard bench for icache against a line-level reference model
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        jump_or_not_in = 1'b0;
    logic        if_enable_in = 1'b0;
    logic [31:0] if_address_in = '0;
    logic [31:0] if_inst_out;
    logic        if_valid_out;
    logic        mem_req_out;
    logic [31:0] mem_address_out;
    logic [31:0] mem_data_in = '0;
    logic        mem_done_in = 1'b0;
    logic        mem_busy_in = 1'b0;

    icache dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .jump_or_not_in  (jump_or_not_in),
        .if_enable_in    (if_enable_in),
        .if_address_in   (if_address_in),
        .if_inst_out     (if_inst_out),
        .if_valid_out    (if_valid_out),
        .mem_req_out     (mem_req_out),
        .mem_address_out (mem_address_out),
        .mem_data_in     (mem_data_in),
        .mem_done_in     (mem_done_in),
        .mem_busy_in     (mem_busy_in)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int pulses_seen = 0;
    int pulses_expected = 0;
    logic [31:0] exp_q[$];

    // Reference model: 256 one-word lines, index = word address mod 256, tag = next 8 bits.
    bit          m_valid [256];
    int          m_tag   [256];
    logic [31:0] m_data  [256];

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 4) % 256);
    endfunction

    function automatic int tag_of(input logic [31:0] a);
        return int'((a / 1024) % 256);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input logic [31:0] d);
        exp_q.push_back(d);
        pulses_expected++;
    endtask

    always @(negedge clk_in) begin
        if (if_valid_out) begin
            pulses_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got inst %h expected no pulse", if_inst_out);
            end else begin
                check("inst", if_inst_out, exp_q.pop_front());
            end
        end
    end

    task automatic cycle();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // mode 0: normal fill, 1: jump aborts before done, 2: jump coincides with done.
    task automatic fetch(input logic [31:0] a, input int mode, input int wait_cycles,
                         input logic [31:0] d);
        bit hit;
        int w;
        hit = model_hit(a);
        if_enable_in  = 1'b1;
        if_address_in = a;
        if (hit) expect_pulse(m_data[idx_of(a)]);
        cycle();
        check("req_after_lookup", {31'b0, mem_req_out}, {31'b0, !hit});
        if (hit) begin
            if_enable_in = 1'b0;
            return;
        end
        check("miss_address", mem_address_out, a);
        w = (wait_cycles < 0) ? int'($urandom_range(0, 5)) : wait_cycles;
        for (int i = 0; i < w; i++) begin
            mem_busy_in = 1'($urandom_range(0, 1));
            cycle();
            check("req_held", {31'b0, mem_req_out}, 32'd1);
            check("addr_held", mem_address_out, a);
        end
        mem_busy_in = 1'b0;
        if (mode == 1) begin
            jump_or_not_in = 1'b1;
            if_enable_in   = 1'b0;
            cycle();
            jump_or_not_in = 1'b0;
            check("req_after_abort", {31'b0, mem_req_out}, 32'd0);
            return;
        end
        mem_done_in = 1'b1;
        mem_data_in = d;
        if (mode == 2) begin
            jump_or_not_in = 1'b1;
            if_enable_in   = 1'b0;
        end else begin
            expect_pulse(d);
        end
        m_valid[idx_of(a)] = 1'b1;
        m_tag[idx_of(a)]   = tag_of(a);
        m_data[idx_of(a)]  = d;
        cycle();
        mem_done_in    = 1'b0;
        jump_or_not_in = 1'b0;
        if_enable_in   = 1'b0;
        check("req_after_done", {31'b0, mem_req_out}, 32'd0);
    endtask

    task automatic burst(input logic [31:0] a, input int n);
        if_enable_in  = 1'b1;
        if_address_in = a;
        for (int i = 0; i < n; i++) begin
            expect_pulse(m_data[idx_of(a)]);
            cycle();
            check("burst_no_req", {31'b0, mem_req_out}, 32'd0);
        end
        if_enable_in = 1'b0;
    endtask

    task automatic idle_jump(input logic [31:0] a);
        if_enable_in   = 1'b1;
        if_address_in  = a;
        jump_or_not_in = 1'b1;
        cycle();
        jump_or_not_in = 1'b0;
        if_enable_in   = 1'b0;
        check("idle_jump_no_req", {31'b0, mem_req_out}, 32'd0);
    endtask

    task automatic reset_during_miss(input logic [31:0] a);
        if (model_hit(a)) return;
        if_enable_in  = 1'b1;
        if_address_in = a;
        cycle();
        check("rst_miss_req", {31'b0, mem_req_out}, 32'd1);
        cycle();
        rst_in       = 1'b1;
        if_enable_in = 1'b0;
        cycle();
        check("rst_drops_req", {31'b0, mem_req_out}, 32'd0);
        check("rst_addr", mem_address_out, 32'd0);
        rst_in = 1'b0;
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int r;
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        repeat (2) cycle();
        check("reset_valid", {31'b0, if_valid_out}, 32'd0);
        check("reset_req", {31'b0, mem_req_out}, 32'd0);
        check("reset_addr", mem_address_out, 32'd0);
        check("reset_inst", if_inst_out, 32'd0);
        rst_in = 1'b0;
        cycle();

        fetch(32'h0000_0000, 0, 5, 32'h0000_0513);
        fetch(32'h0000_0000, 0, 0, 32'h0);
        burst(32'h0000_0000, 4);
        fetch(32'h0000_0400, 0, 3, 32'h1234_5678);
        fetch(32'h0000_0000, 0, 2, 32'h0000_0513);
        fetch(32'h0000_0010, 1, 1, 32'h0);
        fetch(32'h0000_0010, 0, 4, 32'h0000_0093);
        fetch(32'h0000_0020, 2, 5, 32'hDEAD_BEEF);
        fetch(32'h0000_0020, 0, 0, 32'h0);
        idle_jump(32'h0000_0020);
        idle_jump(32'h0000_0030);
        reset_during_miss(32'h0000_0040);
        fetch(32'h0000_0000, 0, 1, 32'hAAAA_0001);
        fetch(32'h0000_0020, 0, 1, 32'hAAAA_0002);

        for (int it = 0; it < 300; it++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2);
            r = int'($urandom_range(0, 19));
            if (r == 0)                          fetch(a, 1, -1, 32'h0);
            else if (r == 1)                     fetch(a, 2, -1, $urandom);
            else if (r == 2)                     idle_jump(a);
            else if (r == 3 && model_hit(a))     burst(a, int'($urandom_range(2, 4)));
            else if (r == 4)                     reset_during_miss(a);
            else                                 fetch(a, 0, -1, $urandom);
            if ($urandom_range(0, 3) == 0) cycle();
        end

        repeat (3) cycle();
        check("pulse_count", 32'(pulses_seen), 32'(pulses_expected));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
